// File: rtl/matrix_drain_pkg.sv
// Shared types for the matrix read-drain engine: bank geometry, FSM encoding
// and the read tag that travels alongside each in-flight memory read.
package matrix_drain_pkg;

   localparam int NUM_BANKS = 16;
   localparam int BANK_W    = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      FLUSH = ST_FLUSH,
      DONE  = ST_DONE
   } state_e;

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic              last;
   } tag_t;

   localparam int TAG_W = BANK_W + 1;

endpackage

// File: rtl/matrix_drain_fifo.sv
// First-word-fall-through FIFO used as the drain output buffer.
// Storage is reset so the exported data reads zero after reset.
module sync_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       empty_o,
   output logic                       full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/matrix_drain.sv
// Read-side initiator for the 16-bank matrix memory: walks a word range across
// all banks (address outer, bank inner) and streams the words out with backpressure.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing one broadcast read per cycle while output credit remains
// FLUSH | all reads issued; draining pipe and FIFO until the last beat leaves
// DONE  | one-cycle completion pulse
module matrix_drain #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BANKS  = 16,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [ADDR_WIDTH-1:0]           base_addr,
   input  logic [15:0]                     num_words,
   output logic                            busy,
   output logic                            done,
   output logic [ADDR_WIDTH-1:0]           addr_matrix,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] dout_matrix_flat,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic [3:0]                      m_bank,
   output logic                            m_last
);

   import matrix_drain_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int FW    = DATA_WIDTH + TAG_W;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [15:0]             nwords_q, nwords_d;
   logic [15:0]             widx_q, widx_d;
   logic [BANK_W-1:0]       bank_q, bank_d;

   logic [RD_LAT:0]         pipe_vld_q;
   tag_t [RD_LAT:0]         pipe_tag_q;

   logic                    issue;
   logic                    issue_last;
   tag_t                    issue_tag;
   logic [7:0]              inflight;
   logic [7:0]              credit_used;
   logic                    credit_ok;

   logic                    cap_vld;
   tag_t                    cap_tag;
   logic [DATA_WIDTH-1:0]   cap_data;

   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic [FW-1:0]           fifo_wdata;
   logic [FW-1:0]           fifo_rdata;
   logic [CNT_W-1:0]        fifo_count;

   // Every issued read owns a FIFO slot from issue until pop, so the FIFO cannot overflow.
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= RD_LAT; i++) begin
         inflight = inflight + 8'(pipe_vld_q[i]);
      end
   end

   assign credit_used = inflight + 8'(fifo_count);
   assign credit_ok   = (credit_used < 8'(FIFO_DEPTH));
   assign issue_last  = (widx_q == nwords_q - 16'd1) && (bank_q == {BANK_W{1'b1}});
   assign issue       = (state_q == ISSUE) && credit_ok;
   assign issue_tag   = '{bank: bank_q, last: issue_last};

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      addr_d   = addr_q;
      nwords_d = nwords_q;
      widx_d   = widx_q;
      bank_d   = bank_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d   = base_addr & ~ADDR_WIDTH'(3);
               nwords_d = num_words;
               widx_d   = '0;
               bank_d   = '0;
               // A zero-length job still passes through FLUSH so busy is seen for a cycle.
               state_d  = (num_words == 16'd0) ? FLUSH : ISSUE;
            end
         end
         ISSUE: begin
            if (issue) begin
               addr_d = base_q + ADDR_WIDTH'({widx_q, 2'b00});
               bank_d = bank_q + BANK_W'(1);
               if (bank_q == {BANK_W{1'b1}}) begin
                  widx_d = widx_q + 16'd1;
               end
               if (issue_last) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (!(|pipe_vld_q) &&
                (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop))) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         base_q   <= '0;
         addr_q   <= '0;
         nwords_q <= '0;
         widx_q   <= '0;
         bank_q   <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         addr_q   <= addr_d;
         nwords_q <= nwords_d;
         widx_q   <= widx_d;
         bank_q   <= bank_d;
      end
   end

   // Stage 0 lines up with the cycle the new address is presented; data returns RD_LAT later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_q <= '0;
         pipe_tag_q <= '0;
      end else begin
         pipe_vld_q[0] <= issue;
         pipe_tag_q[0] <= issue_tag;
         for (int i = 1; i <= RD_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_tag_q[i] <= pipe_tag_q[i-1];
         end
      end
   end

   assign cap_vld    = pipe_vld_q[RD_LAT];
   assign cap_tag    = pipe_tag_q[RD_LAT];
   assign cap_data   = dout_matrix_flat[cap_tag.bank*DATA_WIDTH +: DATA_WIDTH];
   assign fifo_wdata = {cap_data, cap_tag};
   assign fifo_push  = cap_vld;
   assign fifo_pop   = m_valid && m_ready;

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_push && fifo_full && !fifo_pop));

   assign busy        = (state_q == ISSUE) || (state_q == FLUSH);
   assign done        = (state_q == DONE);
   assign addr_matrix = addr_q;
   assign m_valid     = !fifo_empty;
   assign m_data      = fifo_rdata[FW-1:TAG_W];
   assign m_bank      = fifo_rdata[TAG_W-1:1];
   assign m_last      = fifo_rdata[0];

endmodule
